// File: rtl/pong_pkg.sv
// Shared types for the Pong match sequencer: state encodings, winner codes,
// BCD digit type and small scoring helpers.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef logic [3:0] bcd_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

    // A score at the target wins outright; otherwise the higher score wins.
    function automatic logic [1:0] pick_winner(input logic [3:0] s1,
                                               input logic [3:0] s2,
                                               input logic [3:0] win);
        if (s1 == win)     return WIN_P1;
        else if (s2 == win) return WIN_P2;
        else if (s1 > s2)  return WIN_P1;
        else if (s2 > s1)  return WIN_P2;
        else               return WIN_DRAW;
    endfunction

endpackage

// File: rtl/bcd_countdown.sv
// Two-digit BCD down-counter with load and decrement enable; holds at 00.
module bcd_countdown
    import pong_pkg::*;
#(
    parameter int INIT = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       zero
);

    localparam bcd_t INIT_TENS = 4'(INIT / 10);
    localparam bcd_t INIT_ONES = 4'(INIT % 10);

    bcd_t tens_q, tens_d;
    bcd_t ones_q, ones_d;

    assign zero = (tens_q == 4'd0) && (ones_q == 4'd0);
    assign tens = tens_q;
    assign ones = ones_q;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (load) begin
            tens_d = INIT_TENS;
            ones_d = INIT_ONES;
        end else if (dec && !zero) begin
            if (ones_q == 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tens_q <= INIT_TENS;
            ones_q <= INIT_ONES;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: gates the ball/paddle datapath, keeps score, runs
// the countdown match timer and decides the winner.
//
// state | meaning
// IDLE  | waiting for start, datapath held centred
// SERVE | centred pause of SERVE_FRAMES frames before a serve
// PLAY  | datapath stepping once per frame, match timer running
// POINT | pause of POINT_FRAMES frames after a miss
// OVER  | match finished, winner latched until the next start
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int MATCH_SECONDS = 60,
    parameter int WIN_SCORE     = 7,
    parameter int SERVE_FRAMES  = 60,
    parameter int POINT_FRAMES  = 90
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       miss1,
    input  logic       miss2,
    output logic       stop,
    output logic       step,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [3:0] sec1,
    output logic [3:0] sec0,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam int              PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [7:0]      SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0]      POINT_LAST = 8'(POINT_FRAMES - 1);
    localparam logic [3:0]      WIN        = 4'(WIN_SCORE);

    state_e        state_q, state_d;
    logic          start_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    frame_q, frame_d;
    logic [3:0]    score1_q, score1_d;
    logic [3:0]    score2_q, score2_d;
    logic [1:0]    winner_q, winner_d;
    logic          stop_q, stop_d;
    logic          step_q, step_d;
    logic          game_over_q, game_over_d;

    logic          start_rise;
    logic          timer_load;
    logic          timer_dec;
    logic          timer_zero;
    logic          last_second;
    logic [3:0]    sec1_w, sec0_w;

    bcd_countdown #(
        .INIT (MATCH_SECONDS)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .dec  (timer_dec),
        .tens (sec1_w),
        .ones (sec0_w),
        .zero (timer_zero)
    );

    always_comb begin
        start_rise  = start & ~start_q;
        timer_dec   = (state_q == ST_PLAY) && (presc_q == PRESC_MAX) && !timer_zero;
        last_second = timer_dec && (sec1_w == 4'd0) && (sec0_w == 4'd1);
        timer_load  = (state_q == ST_OVER) && start_rise;

        state_d  = state_q;
        presc_d  = presc_q;
        frame_d  = frame_q;
        score1_d = score1_q;
        score2_d = score2_q;
        winner_d = winner_q;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) state_d = ST_SERVE;
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (frame_q == SERVE_LAST) state_d = ST_PLAY;
                    else                       frame_d = frame_q + 8'd1;
                end
            end
            ST_PLAY: begin
                presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
                // A miss beats a simultaneous timeout; POINT then ends the match.
                if (miss1 | miss2) begin
                    state_d = ST_POINT;
                    if (miss1 && !miss2)      score2_d = sat_inc(score2_q);
                    else if (miss2 && !miss1) score1_d = sat_inc(score1_q);
                end else if (last_second || timer_zero) begin
                    state_d = ST_OVER;
                end
            end
            ST_POINT: begin
                if (frame_tick) begin
                    if (frame_q == POINT_LAST) begin
                        if (score1_q == WIN || score2_q == WIN || timer_zero)
                            state_d = ST_OVER;
                        else
                            state_d = ST_SERVE;
                    end else begin
                        frame_d = frame_q + 8'd1;
                    end
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    state_d  = ST_SERVE;
                    score1_d = 4'd0;
                    score2_d = 4'd0;
                    winner_d = WIN_NONE;
                    presc_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) frame_d = 8'd0;
        if (state_d == ST_OVER && state_q != ST_OVER)
            winner_d = pick_winner(score1_d, score2_d, WIN);

        stop_d      = (state_d != ST_PLAY);
        step_d      = (state_q == ST_PLAY) && frame_tick;
        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            presc_q     <= '0;
            frame_q     <= 8'd0;
            score1_q    <= 4'd0;
            score2_q    <= 4'd0;
            winner_q    <= WIN_NONE;
            stop_q      <= 1'b1;
            step_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            presc_q     <= presc_d;
            frame_q     <= frame_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            winner_q    <= winner_d;
            stop_q      <= stop_d;
            step_q      <= step_d;
            game_over_q <= game_over_d;
        end
    end

    assign stop      = stop_q;
    assign step      = step_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign sec1      = sec1_w;
    assign sec0      = sec0_w;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: a match-level model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_pong_match_ctrl;

    localparam int CLK_HZ        = 10;
    localparam int MATCH_SECONDS = 12;
    localparam int WIN_SCORE     = 3;
    localparam int SERVE_FRAMES  = 2;
    localparam int POINT_FRAMES  = 3;

    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;

    logic       clk, rst, frame_tick, start, miss1, miss2;
    logic       stop, step, game_over;
    logic [3:0] score1, score2, sec1, sec0;
    logic [1:0] winner;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    pong_match_ctrl #(
        .CLK_HZ        (CLK_HZ),
        .MATCH_SECONDS (MATCH_SECONDS),
        .WIN_SCORE     (WIN_SCORE),
        .SERVE_FRAMES  (SERVE_FRAMES),
        .POINT_FRAMES  (POINT_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .miss1      (miss1),
        .miss2      (miss2),
        .stop       (stop),
        .step       (step),
        .score1     (score1),
        .score2     (score2),
        .sec1       (sec1),
        .sec0       (sec0),
        .game_over  (game_over),
        .winner     (winner),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Match-level model: plain integers for scores, seconds left, frames seen
    // in the current pause and PLAY cycles since the last whole second.
    int m_state = M_IDLE, m_s1 = 0, m_s2 = 0, m_secs = MATCH_SECONDS;
    int m_play_cyc = 0, m_frames = 0, m_winner = 0, m_step = 0;
    bit m_start_prev = 0;

    function automatic int m_pick(input int a, input int b);
        if (a == WIN_SCORE) return 1;
        if (b == WIN_SCORE) return 2;
        if (a > b) return 1;
        if (b > a) return 2;
        return 3;
    endfunction

    function automatic int m_bump(input int s);
        return (s < 15) ? s + 1 : 15;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_state = M_IDLE; m_s1 = 0; m_s2 = 0; m_secs = MATCH_SECONDS;
            m_play_cyc = 0; m_frames = 0; m_winner = 0; m_step = 0;
            m_start_prev = 0;
        end else begin
            bit rise;
            rise   = start && !m_start_prev;
            m_step = (m_state == M_PLAY && frame_tick) ? 1 : 0;
            case (m_state)
                M_IDLE: if (rise) begin m_state = M_SERVE; m_frames = 0; end
                M_SERVE: if (frame_tick) begin
                    m_frames++;
                    if (m_frames == SERVE_FRAMES) begin m_state = M_PLAY; m_frames = 0; end
                end
                M_PLAY: begin
                    m_play_cyc++;
                    if (m_play_cyc == CLK_HZ) begin
                        m_play_cyc = 0;
                        if (m_secs > 0) m_secs--;
                    end
                    if (miss1 || miss2) begin
                        if (miss1 && !miss2) m_s2 = m_bump(m_s2);
                        if (miss2 && !miss1) m_s1 = m_bump(m_s1);
                        m_state = M_POINT; m_frames = 0;
                    end else if (m_secs == 0) begin
                        m_state = M_OVER; m_winner = m_pick(m_s1, m_s2);
                    end
                end
                M_POINT: if (frame_tick) begin
                    m_frames++;
                    if (m_frames == POINT_FRAMES) begin
                        m_frames = 0;
                        if (m_s1 == WIN_SCORE || m_s2 == WIN_SCORE || m_secs == 0) begin
                            m_state = M_OVER; m_winner = m_pick(m_s1, m_s2);
                        end else begin
                            m_state = M_SERVE;
                        end
                    end
                end
                M_OVER: if (rise) begin
                    m_state = M_SERVE; m_s1 = 0; m_s2 = 0; m_winner = 0;
                    m_secs = MATCH_SECONDS; m_play_cyc = 0; m_frames = 0;
                end
                default: m_state = M_IDLE;
            endcase
            m_start_prev = start;
        end
    end

    always @(negedge clk) begin
        check("state", int'(state), m_state);
        check("stop", int'(stop), (m_state != M_PLAY) ? 1 : 0);
        check("step", int'(step), m_step);
        check("score1", int'(score1), m_s1);
        check("score2", int'(score2), m_s2);
        check("sec1", int'(sec1), m_secs / 10);
        check("sec0", int'(sec0), m_secs % 10);
        check("game_over", int'(game_over), (m_state == M_OVER) ? 1 : 0);
        check("winner", int'(winner), m_winner);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    initial begin
        int n;
        rst = 1'b1; frame_tick = 1'b0; start = 1'b0; miss1 = 1'b0; miss2 = 1'b0;
        repeat (3) cyc();
        check("rst_state", int'(state), 0);
        check("rst_stop", int'(stop), 1);
        check("rst_sec", int'({sec1, sec0}), 8'h12);
        check("rst_winner", int'(winner), 0);

        // start -> SERVE, two ticks -> PLAY, step one cycle after frame_tick
        rst = 1'b0; start = 1'b1;
        cyc();
        check("start_serve", int'(state), 1);
        start = 1'b0;
        cyc();
        tick();
        check("serve_hold", int'(state), 1);
        tick();
        check("play", int'(state), 2);
        check("play_stop", int'(stop), 0);
        frame_tick = 1'b1;
        cyc();
        check("step_hi", int'(step), 1);
        frame_tick = 1'b0;
        cyc();
        check("step_lo", int'(step), 0);

        // miss1 held for 20 cycles scores once
        miss1 = 1'b1;
        cyc();
        check("miss1_point", int'(state), 3);
        repeat (19) cyc();
        miss1 = 1'b0;
        check("miss1_once", int'(score2), 1);
        tick(); tick();
        check("point_hold", int'(state), 3);
        tick();
        check("point_serve", int'(state), 1);
        tick(); tick();

        // simultaneous misses: pause, no score
        miss1 = 1'b1; miss2 = 1'b1;
        cyc();
        miss1 = 1'b0; miss2 = 1'b0;
        check("both_point", int'(state), 3);
        check("both_s1", int'(score1), 0);
        check("both_s2", int'(score2), 1);
        repeat (3) tick();
        tick(); tick();

        // three miss2 events -> player 1 reaches WIN_SCORE
        for (int i = 0; i < 3; i++) begin
            miss2 = 1'b1;
            cyc();
            miss2 = 1'b0;
            check("miss2_score", int'(score1), i + 1);
            repeat (3) tick();
            if (i < 2) begin tick(); tick(); end
        end
        check("win_over", int'(state), 4);
        check("win_p1", int'(winner), 1);
        check("win_go", int'(game_over), 1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("restart_state", int'(state), 1);
        check("restart_s1", int'(score1), 0);
        check("restart_sec", int'({sec1, sec0}), 8'h12);
        cyc();

        // timeout with a pause mid-match; pause must not advance the timer
        tick(); tick();
        repeat (34) cyc();
        check("t35_sec", int'({sec1, sec0}), 8'h09);
        miss1 = 1'b1; miss2 = 1'b1;
        cyc();
        miss1 = 1'b0; miss2 = 1'b0;
        repeat (3) tick();
        repeat (7) cyc();
        tick(); tick();
        check("pause_sec", int'({sec1, sec0}), 8'h09);
        n = 0;
        while (state == 3'd2 && n < 200) begin
            frame_tick = (n % 8 == 0);
            cyc();
            n++;
        end
        frame_tick = 1'b0;
        check("timeout_cycles", n, 83);
        check("timeout_over", int'(state), 4);
        check("timeout_draw", int'(winner), 3);
        check("timeout_sec", int'({sec1, sec0}), 0);

        // miss in the cycle the timer hits 00
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        tick(); tick();
        repeat (118) cyc();
        miss1 = 1'b1;
        cyc();
        miss1 = 1'b0;
        check("late_point", int'(state), 3);
        check("late_score", int'(score2), 1);
        check("late_sec", int'({sec1, sec0}), 0);
        repeat (3) tick();
        check("late_over", int'(state), 4);
        check("late_p2", int'(winner), 2);

        // reset in PLAY overrides all other inputs
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        tick(); tick();
        repeat (5) cyc();
        check("pre_rst_play", int'(state), 2);
        rst = 1'b1; miss1 = 1'b1; start = 1'b1; frame_tick = 1'b1;
        cyc();
        check("rst_mid_state", int'(state), 0);
        check("rst_mid_stop", int'(stop), 1);
        check("rst_mid_step", int'(step), 0);
        check("rst_mid_sec", int'({sec1, sec0}), 8'h12);
        check("rst_mid_go", int'(game_over), 0);
        rst = 1'b0; miss1 = 1'b0; start = 1'b0; frame_tick = 1'b0;
        cyc();
        check("rst_mid_idle", int'(state), 0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
